// File: rtl/core_if_pkg.sv
// core_if_pkg: Core interface widths and reader FSM state encoding.
package core_if_pkg;
  localparam int CORE_ADDR_W = 12;
  localparam int LANE_W = 2;
  localparam int ENTRY_W = 10;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_COMPUTE = 3'd1;
  localparam state_t S_LANE = 3'd2;
  localparam state_t S_PUSH = 3'd3;
  localparam state_t S_FIN = 3'd4;
endpackage

// File: rtl/core_nibble_assembler.sv
// core_nibble_assembler: collects single-bit Core samples into a 4-bit entry.
module core_nibble_assembler
  import core_if_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              strobe,
  input  logic [LANE_W-1:0] lane,
  input  logic              sample,
  output logic [3:0]        nibble
);
  always_ff @(posedge clk or posedge rst)
    if (rst) nibble <= '0;
    else if (clear) nibble <= '0;
    else if (strobe) nibble[lane] <= sample;
endmodule

// File: rtl/core_result_reader.sv
// core_result_reader: runs Core for COMPUTE_CYCLES, then streams its bit-addressed results as nibbles.
// Optional READER_CHECKSUM_EN adds a running 16-bit sum of accepted nibbles.
module core_result_reader
  import core_if_pkg::*;
#(
  parameter int COMPUTE_CYCLES = 589831,
  parameter int RD_LAT = 1,
  parameter int DEPTH = 1024,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   core_en,
  output logic [CORE_ADDR_W-1:0] core_addr,
  input  logic                   core_out,
  output logic [3:0]             out_data,
  output logic [ENTRY_W-1:0]     out_index,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
`ifdef READER_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);
  localparam int CW = $clog2(COMPUTE_CYCLES + 1);
  state_t state;
  logic [CW-1:0] cyc;
  logic [1:0] lat;
  logic [LANE_W-1:0] lane;
  logic [ENTRY_W-1:0] entry;
  logic [3:0] nib;
  logic strobe, lane_last, entry_last, accept, launch, clear;
  always_comb begin
    strobe = state == S_LANE && lat == 2'(RD_LAT);
    lane_last = lane == LANE_W'(LANES - 1);
    entry_last = entry == ENTRY_W'(DEPTH - 1);
    accept = state == S_PUSH && out_ready;
    launch = state == S_IDLE && start;
    clear = launch || accept;
  end
  assign busy = state != S_IDLE;
  core_nibble_assembler u_asm (
    .clk(clk), .rst(rst), .clear(clear), .strobe(strobe),
    .lane(lane), .sample(core_out), .nibble(nib)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      core_en <= 1'b0;
      core_addr <= '0;
      out_data <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
      cyc <= '0;
      lat <= '0;
      lane <= '0;
      entry <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE:
          if (start) begin
            state <= S_COMPUTE;
            core_en <= 1'b1;
            cyc <= '0;
          end
        S_COMPUTE:
          if (cyc == CW'(COMPUTE_CYCLES - 1)) begin
            state <= S_LANE;
            core_en <= 1'b0;
            core_addr <= '0;
            lane <= '0;
            entry <= '0;
            lat <= '0;
          end else cyc <= cyc + 1'b1;
        S_LANE:
          if (!strobe) lat <= lat + 1'b1;
          else begin
            lat <= '0;
            // Lane 3 is the final bit: merge it straight into the emitted nibble.
            if (lane_last) begin
              state <= S_PUSH;
              out_data <= nib | {core_out, 3'b000};
              out_index <= entry;
              out_valid <= 1'b1;
              core_addr <= {entry, 2'b00};
              lane <= '0;
            end else begin
              lane <= lane + 1'b1;
              core_addr <= {entry, lane + 1'b1};
            end
          end
        S_PUSH:
          if (out_ready) begin
            out_valid <= 1'b0;
            if (entry_last) begin
              state <= S_FIN;
              done <= 1'b1;
              core_addr <= '0;
            end else begin
              state <= S_LANE;
              entry <= entry + 1'b1;
              core_addr <= {entry + 1'b1, 2'b00};
            end
          end
        S_FIN: begin
          state <= S_IDLE;
          core_addr <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
`ifdef READER_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) checksum <= '0;
    else if (launch) checksum <= '0;
    else if (accept) checksum <= checksum + 16'(out_data);
`endif
endmodule

// File: tb/tb_core_result_reader.sv
// tb_core_result_reader: directed bench for core_result_reader at RD_LAT 0, 1 and 3 plus a long-compute reset instance.
module tb_core_result_reader;
  logic clk, rst;
  int cyc = 0;
  int checks = 0;
  int fails = 0;
  bit fin_go = 0;
  logic start_s [3];
  logic ready_s [3];
  logic start3, en3, core_out3, valid3, busy3, done3;
  logic [11:0] addr3;
  logic [3:0] data3;
  logic [9:0] index3;
`ifdef READER_CHECKSUM_EN
  logic [15:0] checksum3;
`endif

  typedef struct { int g; int idx; logic [3:0] data; } vec_t;
  vec_t tbl [12];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model(input bit allf, input int idx);
    logic [3:0] n;
    n = idx[3:0] ^ 4'hA;
    return allf ? 4'hF : n;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int LAT = g == 0 ? 0 : g == 1 ? 1 : 3;
    localparam int SP = 4 * (LAT + 1) + 1;
`ifdef READER_CHECKSUM_EN
    localparam bit ALLF = (g == 0);
    logic [15:0] checksum;
`else
    localparam bit ALLF = 1'b0;
`endif
    logic core_en, core_out, out_valid, busy, done;
    logic [11:0] core_addr, d1, d2, d3, a;
    logic [3:0] out_data, m;
    logic [9:0] out_index;
    int beats = 0;
    int done_cnt = 0;
    int en_cnt = 0;
    int last_acc = 0;
    logic [3:0] cap [1024];

    core_result_reader #(.COMPUTE_CYCLES(16), .RD_LAT(LAT), .DEPTH(1024), .LANES(4)) dut (
      .clk(clk), .rst(rst), .start(start_s[g]), .core_en(core_en), .core_addr(core_addr),
      .core_out(core_out), .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
      .out_ready(ready_s[g]), .busy(busy), .done(done)
`ifdef READER_CHECKSUM_EN
      , .checksum(checksum)
`endif
    );

    always @(posedge clk) begin
      d1 <= core_addr;
      d2 <= d1;
      d3 <= d2;
    end
    always_comb begin
      a = LAT == 0 ? core_addr : LAT == 1 ? d1 : d3;
      m = model(ALLF, int'(a[11:2]));
      core_out = m[a[1:0]];
    end

    initial forever begin
      @(negedge clk);
      if (core_en) en_cnt++;
      if (out_valid && ready_s[g]) begin
        chk($sformatf("beat_index_g%0d", g), out_index, beats);
        chk($sformatf("beat_data_g%0d", g), out_data, model(ALLF, beats));
        if (beats > 0 && (g != 1 || beats != 5))
          chk($sformatf("beat_spacing_g%0d", g), cyc - last_acc, SP);
        if (beats < 1024) cap[beats] = out_data;
        beats++;
        last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        chk($sformatf("done_gap_g%0d", g), cyc - last_acc, 1);
        chk($sformatf("done_beats_g%0d", g), beats, 1024);
`ifdef READER_CHECKSUM_EN
        chk($sformatf("checksum_g%0d", g), checksum, ALLF ? 16'h3C00 : 16'h1E00);
`endif
      end
    end

    initial begin
      wait (fin_go);
      chk($sformatf("final_done_cnt_g%0d", g), done_cnt, 1);
      chk($sformatf("final_beats_g%0d", g), beats, 1024);
      chk($sformatf("final_en_cnt_g%0d", g), en_cnt, 16);
      chk($sformatf("final_busy_g%0d", g), busy, 0);
    end
  end

  core_result_reader #(.COMPUTE_CYCLES(2000), .RD_LAT(1), .DEPTH(1024), .LANES(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .core_en(en3), .core_addr(addr3),
    .core_out(core_out3), .out_data(data3), .out_index(index3), .out_valid(valid3),
    .out_ready(1'b1), .busy(busy3), .done(done3)
`ifdef READER_CHECKSUM_EN
    , .checksum(checksum3)
`endif
  );

  initial begin
    int n;
    rst = 1;
    start3 = 0;
    core_out3 = 0;
    for (int i = 0; i < 3; i++) begin
      start_s[i] = 0;
      ready_s[i] = 1;
    end
    tbl = '{'{1, 0, 4'hA}, '{1, 1, 4'hB}, '{1, 5, 4'hF}, '{1, 15, 4'h5},
            '{1, 100, 4'hE}, '{1, 101, 4'hF}, '{1, 512, 4'hA}, '{1, 1023, 4'h5},
            '{2, 0, 4'hA}, '{2, 7, 4'hD}, '{2, 300, 4'h6}, '{2, 1023, 4'h5}};
    repeat (2) @(negedge clk);
    chk("rst_core_en", gd[1].core_en, 0);
    chk("rst_core_addr", gd[1].core_addr, 0);
    chk("rst_out_valid", gd[1].out_valid, 0);
    chk("rst_out_data", gd[1].out_data, 0);
    chk("rst_out_index", gd[1].out_index, 0);
    chk("rst_busy", gd[1].busy, 0);
    chk("rst_done", gd[1].done, 0);
`ifdef READER_CHECKSUM_EN
    chk("rst_checksum", gd[1].checksum, 0);
`endif
    rst = 0;

    // Reset in the middle of a long compute phase, then a clean restart.
    @(posedge clk); #1 start3 = 1;
    @(posedge clk); #1 start3 = 0;
    repeat (1000) @(negedge clk);
    chk("pre_rst_en_busy", {en3, busy3}, 2'b11);
    rst = 1;
    @(posedge clk); #1;
    chk("mid_rst_state", {en3, busy3, addr3}, 14'h0);
    @(negedge clk) rst = 0;
    @(posedge clk); #1 start3 = 1;
    @(posedge clk); #1 start3 = 0;
    n = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (en3) n++;
      else if (n > 0) break;
    end
    chk("restart_compute_len", n, 2000);

    @(posedge clk); #1 for (int i = 0; i < 3; i++) start_s[i] = 1;
    @(posedge clk); #1 for (int i = 0; i < 3; i++) start_s[i] = 0;
    fork
      begin
        for (int i = 0; i < 2000 && gd[1].beats < 5; i++) @(negedge clk);
        chk("wait_beat5", gd[1].beats >= 5, 1);
        @(posedge clk); #1 ready_s[1] = 0;
        for (int i = 0; i < 50 && !gd[1].out_valid; i++) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
          if (i > 0) @(negedge clk);
          chk("bp_hold", {gd[1].out_valid, gd[1].out_index, gd[1].out_data, gd[1].core_addr},
              {1'b1, 10'd5, 4'hF, 12'h014});
        end
        @(posedge clk); #1 ready_s[1] = 1;
        for (int i = 0; i < 3000 && gd[1].beats < 100; i++) @(negedge clk);
        chk("wait_beat100", gd[1].beats >= 100, 1);
        @(posedge clk); #1 start_s[1] = 1;
        @(posedge clk); #1 start_s[1] = 0;
        @(negedge clk);
        chk("start_busy_ignored", {gd[1].busy, gd[1].core_en}, 2'b10);
      end
      begin
        for (int i = 0; i < 20000 && !gd[2].done; i++) @(negedge clk);
        chk("wait_done_g2", gd[2].done, 1);
        start_s[2] = 1;
        @(negedge clk);
        start_s[2] = 0;
        repeat (3) @(negedge clk);
        chk("fin_start_ignored", {gd[2].busy, gd[2].core_en}, 2'b00);
      end
    join
    for (int i = 0; i < 5000 && (gd[0].done_cnt == 0 || gd[1].done_cnt == 0); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    fin_go = 1;
    #1;
    for (int i = 0; i < 12; i++)
      chk($sformatf("table_g%0d_e%0d", tbl[i].g, tbl[i].idx),
          tbl[i].g == 1 ? gd[1].cap[tbl[i].idx] : gd[2].cap[tbl[i].idx], tbl[i].data);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
